// File: rtl/prog_loader_pkg.sv
// ============================================================================
// prog_loader_pkg : shared constants for the instruction-store loader,
//                   CPU core and instruction RAM.  Rev 1.0
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  localparam int          LOADER_ADDR_W = 11;
  localparam int          LOADER_DATA_W = 29;
  localparam logic [7:0]  LOADER_MAGIC  = 8'hA5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_WORD   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// ============================================================================
// prog_loader_if : byte stream in, instruction RAM write port and CPU control
//                  out.  master = loader, slave = byte source / RAM / CPU.  Rev 1.0
// ============================================================================
`default_nettype none

interface prog_loader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 29
);

  logic [7:0]        RxData;
  logic              RxValid;
  logic              RxReady;
  logic              WeIMEM;
  logic [ADDR_W-1:0] AddrIMEM;
  logic [DATA_W-1:0] DataIMEM;
  logic              CpuHold;
  logic              LoadDone;
  logic              LoadErr;

  modport master (
    input  RxData, RxValid,
    output RxReady, WeIMEM, AddrIMEM, DataIMEM, CpuHold, LoadDone, LoadErr
  );

  modport slave (
    output RxData, RxValid,
    input  RxReady, WeIMEM, AddrIMEM, DataIMEM, CpuHold, LoadDone, LoadErr
  );

endinterface

`default_nettype wire

// File: rtl/prog_loader_csum.sv
// ============================================================================
// prog_loader_csum : 8-bit XOR accumulator with synchronous clear and enable.
//                    Rev 1.0
// ============================================================================
`default_nettype none

module prog_loader_csum
  import prog_loader_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       clr,
  input  wire logic       en,
  input  wire logic [7:0] din,
  output logic      [7:0] sum
);

  logic [7:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sum <= 8'h00;
    end else if (en) begin
      r_sum <= csum_fold(r_sum, din);
    end
  end

  assign sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : parses a length-framed byte stream and writes instruction
//               words into the instruction RAM while holding the CPU.  Rev 1.0
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W = LOADER_ADDR_W,
  parameter int         DATA_W = LOADER_DATA_W,
  parameter logic [7:0] MAGIC  = LOADER_MAGIC
) (
  input  wire logic     clk,
  input  wire logic     rst,
  prog_loader_if.master bus
);

  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [1:0]        r_bcnt;
  logic [ADDR_W-1:0] r_index;
  logic [DATA_W-1:0] r_word;
  logic              r_we;
  logic              r_done;
  logic              r_hold;
  logic              r_err;

  logic              w_ready;
  logic              w_xfer;
  logic [15:0]       w_len;
  logic              w_last;
  logic              w_csum_clr;
  logic              w_csum_en;
  logic [7:0]        w_csum;

  assign w_ready = (r_state != S_WRITE) && (r_state != S_DONE);
  assign w_xfer  = bus.RxValid && w_ready;
  assign w_len   = {r_len[15:8], bus.RxData};
  assign w_last  = ({{(16-ADDR_W){1'b0}}, r_index} == (r_len - 16'd1));

  assign w_csum_clr = w_xfer && (r_state == S_IDLE) && (bus.RxData == MAGIC);
  assign w_csum_en  = w_xfer && ((r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                                 (r_state == S_WORD));

  prog_loader_csum u_csum (
    .clk (clk),
    .rst (rst),
    .clr (w_csum_clr),
    .en  (w_csum_en),
    .din (bus.RxData),
    .sum (w_csum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= 16'h0000;
      r_bcnt  <= 2'd0;
      r_index <= '0;
      r_word  <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_hold  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && (bus.RxData == MAGIC)) begin
            r_state <= S_LEN_HI;
            r_hold  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= bus.RxData;
            r_state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= bus.RxData;
            r_index    <= '0;
            r_bcnt     <= 2'd0;
            if (w_len == 16'd0) begin
              r_state <= S_CSUM;
            end else if ({1'b0, w_len} > MAX_LEN) begin
              r_err   <= 1'b1;
              r_hold  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WORD;
            end
          end
        end
        S_WORD: begin
          // Only the low DATA_W bits of the 32-bit big-endian word survive.
          if (w_xfer) begin
            r_word <= DATA_W'({r_word, bus.RxData});
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_we    <= 1'b1;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (w_last) begin
            r_state <= S_CSUM;
          end else begin
            r_index <= r_index + 1'b1;
            r_state <= S_WORD;
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            if (bus.RxData == w_csum) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b1;
              r_hold  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          r_hold  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.RxReady  = w_ready;
  assign bus.WeIMEM   = r_we;
  assign bus.AddrIMEM = r_index;
  assign bus.DataIMEM = r_word;
  assign bus.CpuHold  = r_hold;
  assign bus.LoadDone = r_done;
  assign bus.LoadErr  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : directed frames against prog_loader with hand-computed
//                  expected RAM writes and status flags.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(11), .DATA_W(29)) bus ();

  prog_loader #(.ADDR_W(11), .DATA_W(29), .MAGIC(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Write / done monitor
  logic [10:0] wa [64];
  logic [28:0] wd [64];
  int wn = 0;
  int dn = 0;

  always @(negedge clk) begin
    if (bus.WeIMEM && wn < 64) begin
      wa[wn] = bus.AddrIMEM;
      wd[wn] = bus.DataIMEM;
      wn = wn + 1;
    end
    if (bus.LoadDone) dn = dn + 1;
  end

  byte unsigned fr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic byte unsigned frame_xor();
    byte unsigned x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x = x ^ fr[i];
    return x;
  endfunction

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send(input byte unsigned b);
    int n = 0;
    bus.RxData  = b;
    bus.RxValid = 1'b1;
    while (!bus.RxReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.RxValid = 1'b0;
  endtask

  task automatic send_frame(input int gapmax);
    for (int i = 0; i < fr.size(); i++) begin
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
      send(fr[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int w0, d0;

  initial begin
    bus.RxData  = 8'h00;
    bus.RxValid = 1'b0;
    idle(3);
    rst = 1'b0;

    check("rst_ready",  32'(bus.RxReady),  32'd1);
    check("rst_hold",   32'(bus.CpuHold),  32'd0);
    check("rst_we",     32'(bus.WeIMEM),   32'd0);
    check("rst_done",   32'(bus.LoadDone), 32'd0);
    check("rst_err",    32'(bus.LoadErr),  32'd0);

    // Two-word frame, good checksum (XOR of bytes after MAGIC = 6D)
    w0 = wn; d0 = dn;
    fr = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'hF0, 8'h40, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h20};
    for (int i = 0; i < 4; i++) send(fr[i]);
    check("t1_hold_mid", 32'(bus.CpuHold), 32'd1);
    for (int i = 4; i < fr.size(); i++) send(fr[i]);
    send(8'h6D);
    idle(3);
    check("t1_nwrites", 32'(wn - w0), 32'd2);
    check("t1_addr0",   32'(wa[w0]),     32'h000);
    check("t1_data0",   32'(wd[w0]),     32'h01F040FF);
    check("t1_addr1",   32'(wa[w0 + 1]), 32'h001);
    check("t1_data1",   32'(wd[w0 + 1]), 32'h01000020);
    check("t1_ndone",   32'(dn - d0), 32'd1);
    check("t1_hold",    32'(bus.CpuHold), 32'd0);
    check("t1_err",     32'(bus.LoadErr), 32'd0);

    // Same frame, wrong checksum
    w0 = wn; d0 = dn;
    send_frame(0);
    send(8'h00);
    check("t2_err",     32'(bus.LoadErr), 32'd1);
    check("t2_hold",    32'(bus.CpuHold), 32'd0);
    idle(2);
    check("t2_nwrites", 32'(wn - w0), 32'd2);
    check("t2_data1",   32'(wd[w0 + 1]), 32'h01000020);
    check("t2_ndone",   32'(dn - d0), 32'd0);

    // Empty frame; MAGIC clears the sticky error
    w0 = wn; d0 = dn;
    send(8'hA5);
    check("t3_err_clr", 32'(bus.LoadErr), 32'd0);
    send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    check("t3_nwrites", 32'(wn - w0), 32'd0);
    check("t3_ndone",   32'(dn - d0), 32'd1);

    // LEN = 0x0801 exceeds 2048 words
    w0 = wn; d0 = dn;
    send(8'hA5); send(8'h08); send(8'h01);
    check("t3_len_err",  32'(bus.LoadErr), 32'd1);
    check("t3_len_hold", 32'(bus.CpuHold), 32'd0);
    check("t3_len_rdy",  32'(bus.RxReady), 32'd1);
    idle(2);
    check("t3_len_nwr",  32'(wn - w0), 32'd0);

    // All-ones word: top three bits dropped, checksum 01^FF^FF^FF^FF = 01
    w0 = wn; d0 = dn;
    fr = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    fr.push_back(frame_xor());
    send_frame(0);
    idle(2);
    check("t4_nwrites", 32'(wn - w0), 32'd1);
    check("t4_data",    32'(wd[w0]), 32'h1FFFFFFF);
    check("t4_err",     32'(bus.LoadErr), 32'd0);
    check("t4_ndone",   32'(dn - d0), 32'd1);

    // Junk before MAGIC, random RxValid gaps
    w0 = wn; d0 = dn;
    fr = '{8'h00, 8'h3C, 8'hA5, 8'h00, 8'h02, 8'h01, 8'hF0, 8'h40, 8'hFF,
           8'h01, 8'h00, 8'h00, 8'h20, 8'h6D};
    send_frame(3);
    idle(3);
    check("t5_nwrites", 32'(wn - w0), 32'd2);
    check("t5_data0",   32'(wd[w0]),     32'h01F040FF);
    check("t5_addr1",   32'(wa[w0 + 1]), 32'h001);
    check("t5_data1",   32'(wd[w0 + 1]), 32'h01000020);
    check("t5_ndone",   32'(dn - d0), 32'd1);
    check("t5_err",     32'(bus.LoadErr), 32'd0);

    // Reset mid-frame, then a fresh frame
    fr = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'hF0, 8'h40};
    send_frame(0);
    check("t6_hold_pre", 32'(bus.CpuHold), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_hold_rst", 32'(bus.CpuHold), 32'd0);
    check("t6_rdy_rst",  32'(bus.RxReady), 32'd1);
    rst = 1'b0;
    w0 = wn; d0 = dn;
    fr = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'hF0, 8'h40, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h20, 8'h6D};
    send_frame(0);
    idle(3);
    check("t6_nwrites", 32'(wn - w0), 32'd2);
    check("t6_data0",   32'(wd[w0]),     32'h01F040FF);
    check("t6_data1",   32'(wd[w0 + 1]), 32'h01000020);
    check("t6_ndone",   32'(dn - d0), 32'd1);
    check("t6_hold",    32'(bus.CpuHold), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
